hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 124 ++++++++++++
 tb/tb_hex_display_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - hex counter/latch driving active-low 7-segment digits
// Optional blink support is built when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    inc,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_n,
  output logic                    ovf
);

  localparam int WW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  logic [WW-1:0] word_q, word_d;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          phase;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CW = $clog2(BLINK_HALF);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CW'(BLINK_HALF - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{blink_mask, BLINK_HALF};
  assign phase      = 1'b0;
`endif

  // Load has priority; an increment only pulses ovf when it actually runs.
  always_comb begin
    word_d = word_q;
    ovf_d  = 1'b0;
    if (load) begin
      word_d = value;
    end else if (inc) begin
      word_d = word_q + WW'(1);
      ovf_d  = &word_q;
    end
  end

  // Walk from the most significant digit; lead stays set while all digits so far are zero.
  logic       lead;
  logic [3:0] nib;
  logic       blank;

  always_comb begin
    seg_d = '0;
    lead  = 1'b1;
    nib   = 4'h0;
    blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib   = word_q[4*i +: 4];
      blank = (lz_en && lead && (nib == 4'h0) && (i != 0)) || (phase && blink_mask[i]);
      seg_d[7*i +: 7] = blank ? 7'h7F : enc(nib);
      if (nib != 4'h0) lead = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      ovf_q  <= 1'b0;
      seg_q  <= {NUM_DIGITS{7'h7F}};
    end else begin
      word_q <= word_d;
      ovf_q  <= ovf_d;
      seg_q  <= seg_d;
    end
  end

  assign seg_n = seg_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - randomized bench for hex_display_ctrl against a behavioural model
module tb_hex_display_ctrl;

  localparam int ND = 4;
  localparam int BH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          inc = 1'b0;
  logic          lz_en = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [27:0]   seg_n;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .inc(inc),
    .lz_en(lz_en), .blink_mask(blink_mask), .seg_n(seg_n), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16];
  initial begin
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  function automatic logic [27:0] render(int unsigned w, bit lz, logic [ND-1:0] mask, bit ph);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      bit bl;
      bl = (lz && i != 0 && (w >> (4*i)) == 0) || (ph && mask[i]);
      r[7*i +: 7] = bl ? 7'h7F : tbl[(w >> (4*i)) % 16];
    end
    return r;
  endfunction

  int unsigned m_word;
  logic        m_ovf;
  logic [27:0] m_seg;
  int unsigned m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word  = 0;
      m_ovf   = 1'b0;
      m_seg   = {4{7'h7F}};
      m_edges = 0;
    end else begin
      bit ph;
`ifdef HEX_DISPLAY_BLINK_EN
      ph = ((m_edges / BH) % 2) == 1;
`else
      ph = 1'b0;
`endif
      m_seg = render(m_word, lz_en, blink_mask, ph);
      m_ovf = inc && !load && (m_word == 32'hFFFF);
      if (load) m_word = value;
      else if (inc) m_word = (m_word + 1) % 65536;
      m_edges++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (seg_n !== {4{7'h7F}}) begin
      errors++;
      $display("FAIL reset_seg got %h exp %h", seg_n, {4{7'h7F}});
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b exp 0", ovf);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (seg_n !== {4{7'h40}}) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", seg_n, {4{7'h40}});
    end
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    inc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg_n !== {4{7'h7F}} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h/%b exp %h/0", seg_n, ovf, {4{7'h7F}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    load = 1'b1; value = 16'h12AF; lz_en = 1'b0; blink_mask = '0;
    step();
    load = 1'b0;
    step();
    checks++;
    if (seg_n !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin
      errors++;
      $display("FAIL load_12af got %h exp %h", seg_n, {7'h79, 7'h24, 7'h08, 7'h0E});
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; value = 16'hFFFF;
    step();
    load = 1'b0; inc = 1'b1;
    step();
    inc = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ovf_pulse got %b exp 1", ovf);
    end
    step();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf_clear got %b exp 0", ovf);
    end
    checks++;
    if (seg_n !== {4{7'h40}}) begin
      errors++;
      $display("FAIL wrap_seg got %h exp %h", seg_n, {4{7'h40}});
    end
  endtask

  task automatic test_priority();
    load = 1'b1; value = 16'hFFFF;
    step();
    value = 16'h0005; inc = 1'b1;
    step();
    load = 1'b0; inc = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL prio_ovf got %b exp 0", ovf);
    end
    step();
    checks++;
    if (seg_n !== {7'h40, 7'h40, 7'h40, 7'h12}) begin
      errors++;
      $display("FAIL prio_seg got %h exp %h", seg_n, {7'h40, 7'h40, 7'h40, 7'h12});
    end
  endtask

  task automatic test_suppress();
    lz_en = 1'b1; load = 1'b1; value = 16'h0000;
    step();
    load = 1'b0;
    step();
    checks++;
    if (seg_n !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      errors++;
      $display("FAIL lz_zero got %h exp %h", seg_n, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    load = 1'b1; value = 16'h0300;
    step();
    load = 1'b0;
    step();
    checks++;
    if (seg_n !== {7'h7F, 7'h30, 7'h40, 7'h40}) begin
      errors++;
      $display("FAIL lz_0300 got %h exp %h", seg_n, {7'h7F, 7'h30, 7'h40, 7'h40});
    end
    lz_en = 1'b0;
    step();
    checks++;
    if (seg_n !== {7'h40, 7'h30, 7'h40, 7'h40}) begin
      errors++;
      $display("FAIL lz_off got %h exp %h", seg_n, {7'h40, 7'h30, 7'h40, 7'h40});
    end
  endtask

  task automatic test_blink();
    int blanks;
    int exp_blanks;
    blanks = 0;
    load = 1'b1; value = 16'h0008; lz_en = 1'b0; blink_mask = 4'b0001;
    step();
    load = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (seg_n[27:7] !== {3{7'h40}}) begin
        errors++;
        $display("FAIL blink_steady got %h exp %h", seg_n[27:7], {3{7'h40}});
      end
      checks++;
      if (seg_n !== m_seg) begin
        errors++;
        $display("FAIL blink_model got %h exp %h", seg_n, m_seg);
      end
      if (seg_n[6:0] == 7'h7F) blanks++;
    end
`ifdef HEX_DISPLAY_BLINK_EN
    exp_blanks = 8;
`else
    exp_blanks = 0;
`endif
    checks++;
    if (blanks != exp_blanks) begin
      errors++;
      $display("FAIL blink_count got %0d exp %0d", blanks, exp_blanks);
    end
    blink_mask = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      load       = ($urandom_range(0, 3) == 0);
      inc        = ($urandom_range(0, 1) == 1);
      value      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      lz_en      = ($urandom_range(0, 1) == 1);
      blink_mask = 4'($urandom);
      rst_n      = ($urandom_range(0, 49) != 0);
      step();
      rst_n = 1'b1;
      checks++;
      if (seg_n !== m_seg) begin
        errors++;
        $display("FAIL rand_seg cycle %0d got %h exp %h", k, seg_n, m_seg);
      end
      checks++;
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_ovf cycle %0d got %b exp %b", k, ovf, m_ovf);
      end
    end
    load = 1'b0;
    inc  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_priority();
    test_suppress();
    test_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
